// File: rtl/sdr_arbiter.sv
// -----------------------------------------------------------------------------
// sdr_arbiter
//
// Schedules every access to the shared SDRAM of the frame-rate converter
// (clk100 domain). Three requesters compete for the single command port of
// the SDRAM sequencer: the input-side write burst, the output-side read burst
// and an internal periodic refresh. One command is in flight at a time; the
// arbiter hands it over with a valid/ready handshake, waits for cmd_done and
// then reports completion to the requester that owned the command.
//
// Ports
//   clk, reset          clock and asynchronous active-high reset
//   wr_req/addr/len     write burst request, held until wr_ack
//   wr_ack, wr_done     one-cycle pulses: command accepted / burst complete
//   rd_req/addr/len     read burst request, held until rd_ack
//   rd_urgent           output FIFO near empty, reads win over writes
//   rd_ack, rd_done     one-cycle pulses: command accepted / burst complete
//   cmd_valid/ready     command handshake towards the sequencer
//   cmd_op              01 write, 10 read, 11 refresh
//   cmd_addr, cmd_len   burst start address and length (length 0 for refresh)
//   cmd_done            one-cycle pulse from the sequencer: command finished
//   refresh_pending     refresh backlog
//   refresh_overflow    sticky: a refresh tick was lost at full backlog
// -----------------------------------------------------------------------------
module sdr_arbiter #(
    parameter int addr_w              = 22,
    parameter int len_w               = 9,
    parameter int refresh_interval    = 780,
    parameter int refresh_max_pending = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [addr_w-1:0] wr_addr,
    input  logic [len_w-1:0]  wr_len,
    output logic              wr_ack,
    output logic              wr_done,
    input  logic              rd_req,
    input  logic [addr_w-1:0] rd_addr,
    input  logic [len_w-1:0]  rd_len,
    input  logic              rd_urgent,
    output logic              rd_ack,
    output logic              rd_done,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        cmd_op,
    output logic [addr_w-1:0] cmd_addr,
    output logic [len_w-1:0]  cmd_len,
    input  logic              cmd_done,
    output logic [2:0]        refresh_pending,
    output logic              refresh_overflow
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] OP_REF  = 2'b11;

    localparam int              tmr_w      = (refresh_interval > 2) ? $clog2(refresh_interval) : 1;
    localparam logic [tmr_w-1:0] tmr_reload = tmr_w'(refresh_interval - 1);
    localparam logic [2:0]       pend_max   = 3'(refresh_max_pending);

    state_t             state, state_nxt;
    logic [tmr_w-1:0]   timer;
    logic               tick;
    logic               ref_done;
    logic               last_rw, last_rw_nxt;

    logic               cmd_valid_nxt;
    logic [1:0]         cmd_op_nxt;
    logic [addr_w-1:0]  cmd_addr_nxt;
    logic [len_w-1:0]   cmd_len_nxt;
    logic               wr_ack_nxt, wr_done_nxt, rd_ack_nxt, rd_done_nxt;

    logic               wr_ok, rd_ok;
    logic [1:0]         grant;
    logic [addr_w-1:0]  grant_addr;
    logic [len_w-1:0]   grant_len;

    // ------------------------------------------------------------------------
    // Refresh timer and backlog
    // ------------------------------------------------------------------------
    assign tick = (timer == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer            <= tmr_reload;
            refresh_pending  <= '0;
            refresh_overflow <= 1'b0;
        end else begin
            timer <= tick ? tmr_reload : timer - tmr_w'(1);
            // A tick landing in the same cycle as a refresh completion cancels
            // out; the tick is not lost, so no overflow either.
            if (tick && !ref_done) begin
                if (refresh_pending == pend_max)
                    refresh_overflow <= 1'b1;
                else
                    refresh_pending <= refresh_pending + 3'd1;
            end else if (!tick && ref_done) begin
                refresh_pending <= refresh_pending - 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Arbitration (used only while IDLE)
    // ------------------------------------------------------------------------
    // A zero-length burst acks while still in IDLE; masking the requester in
    // its ack cycle keeps its still-held request from being granted twice.
    assign wr_ok = wr_req && !wr_ack;
    assign rd_ok = rd_req && !rd_ack;

    always_comb begin
        grant = OP_NONE;
        if (refresh_pending == pend_max)
            grant = OP_REF;
        else if (rd_ok && rd_urgent)
            grant = OP_RD;
        else if (rd_ok && wr_ok)
            grant = last_rw ? OP_RD : OP_WR;
        else if (rd_ok)
            grant = OP_RD;
        else if (wr_ok)
            grant = OP_WR;
        else if (refresh_pending != '0)
            grant = OP_REF;
    end

    assign grant_addr = (grant == OP_RD) ? rd_addr :
                        (grant == OP_WR) ? wr_addr : '0;
    assign grant_len  = (grant == OP_RD) ? rd_len  :
                        (grant == OP_WR) ? wr_len  : '0;

    // ------------------------------------------------------------------------
    // Command FSM: next state and registered outputs
    // ------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        last_rw_nxt   = last_rw;
        cmd_valid_nxt = cmd_valid;
        cmd_op_nxt    = cmd_op;
        cmd_addr_nxt  = cmd_addr;
        cmd_len_nxt   = cmd_len;
        wr_ack_nxt    = 1'b0;
        wr_done_nxt   = 1'b0;
        rd_ack_nxt    = 1'b0;
        rd_done_nxt   = 1'b0;
        ref_done      = 1'b0;

        case (state)
            IDLE: begin
                if (grant != OP_NONE) begin
                    if (grant != OP_REF)
                        last_rw_nxt = (grant == OP_WR);
                    if (grant != OP_REF && grant_len == '0) begin
                        // Nothing to transfer: complete locally, no command.
                        wr_ack_nxt  = (grant == OP_WR);
                        wr_done_nxt = (grant == OP_WR);
                        rd_ack_nxt  = (grant == OP_RD);
                        rd_done_nxt = (grant == OP_RD);
                    end else begin
                        state_nxt     = ISSUE;
                        cmd_valid_nxt = 1'b1;
                        cmd_op_nxt    = grant;
                        cmd_addr_nxt  = grant_addr;
                        cmd_len_nxt   = grant_len;
                    end
                end
            end

            ISSUE: begin
                if (cmd_ready) begin
                    state_nxt     = WAIT_DONE;
                    cmd_valid_nxt = 1'b0;
                    wr_ack_nxt    = (cmd_op == OP_WR);
                    rd_ack_nxt    = (cmd_op == OP_RD);
                end
            end

            WAIT_DONE: begin
                if (cmd_done) begin
                    state_nxt   = IDLE;
                    wr_done_nxt = (cmd_op == OP_WR);
                    rd_done_nxt = (cmd_op == OP_RD);
                    ref_done    = (cmd_op == OP_REF);
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last_rw   <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_op    <= OP_NONE;
            cmd_addr  <= '0;
            cmd_len   <= '0;
            wr_ack    <= 1'b0;
            wr_done   <= 1'b0;
            rd_ack    <= 1'b0;
            rd_done   <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_rw   <= last_rw_nxt;
            cmd_valid <= cmd_valid_nxt;
            cmd_op    <= cmd_op_nxt;
            cmd_addr  <= cmd_addr_nxt;
            cmd_len   <= cmd_len_nxt;
            wr_ack    <= wr_ack_nxt;
            wr_done   <= wr_done_nxt;
            rd_ack    <= rd_ack_nxt;
            rd_done   <= rd_done_nxt;
        end
    end

endmodule

// File: tb/tb_sdr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdr_arbiter
//
// Self-checking bench for sdr_arbiter: a table of single-grant arbitration
// vectors followed by hand-written multi-cycle sequences (lone write,
// contention, periodic and forced refresh, stalled handshake, reset while a
// burst is outstanding). Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sdr_arbiter;

    localparam int AW = 22;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_req, rd_req, rd_urgent, cmd_ready, cmd_done;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [LW-1:0] wr_len, rd_len;
    logic          wr_ack, wr_done, rd_ack, rd_done, cmd_valid, refresh_overflow;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [2:0]    refresh_pending;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sdr_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .wr_req           (wr_req),
        .wr_addr          (wr_addr),
        .wr_len           (wr_len),
        .wr_ack           (wr_ack),
        .wr_done          (wr_done),
        .rd_req           (rd_req),
        .rd_addr          (rd_addr),
        .rd_len           (rd_len),
        .rd_urgent        (rd_urgent),
        .rd_ack           (rd_ack),
        .rd_done          (rd_done),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_addr         (cmd_addr),
        .cmd_len          (cmd_len),
        .cmd_done         (cmd_done),
        .refresh_pending  (refresh_pending),
        .refresh_overflow (refresh_overflow)
    );

    typedef struct {
        logic       rd_req;
        logic       wr_req;
        logic       rd_urgent;
        int         prior;      // 0 none, 1 completed write, 2 completed read
        logic [8:0] wr_len;
        logic [8:0] rd_len;
        logic       exp_valid;
        logic [1:0] exp_op;
        logic       exp_wr_pulse; // wr_ack and wr_done together (zero length)
        logic       exp_rd_pulse; // rd_ack and rd_done together (zero length)
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic sel_sig(input int which);
        case (which)
            0:       return wr_ack;
            1:       return wr_done;
            2:       return rd_ack;
            3:       return rd_done;
            4:       return cmd_valid;
            5:       return refresh_pending == 3'd4;
            6:       return refresh_overflow;
            default: return refresh_pending != 3'd0;
        endcase
    endfunction

    // Returns the number of falling edges until the signal is seen, or -1.
    task automatic wait_sig(input int which, input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (sel_sig(which)) begin
                cycles = i;
                return;
            end
        end
    endtask

    // Leaves reset released right at a falling edge, inputs idle, ready high.
    task automatic apply_reset();
        reset     = 1'b1;
        wr_req    = 1'b0;
        rd_req    = 1'b0;
        rd_urgent = 1'b0;
        cmd_done  = 1'b0;
        cmd_ready = 1'b1;
        wr_addr   = '0;
        rd_addr   = '0;
        wr_len    = '0;
        rd_len    = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // A complete length-4 burst, used to set up the read/write history.
    task automatic do_txn(input bit is_read);
        int c;
        if (is_read) begin
            rd_req = 1'b1; rd_addr = 22'h0AAAAA; rd_len = 9'd4;
        end else begin
            wr_req = 1'b1; wr_addr = 22'h055555; wr_len = 9'd4;
        end
        wait_sig(is_read ? 2 : 0, 10, c);
        check(is_read ? "setup rd_ack seen" : "setup wr_ack seen", 32'(c >= 0), 32'd1);
        rd_req   = 1'b0;
        wr_req   = 1'b0;
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;
        check(is_read ? "setup rd_done" : "setup wr_done",
              32'(is_read ? rd_done : wr_done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[12];
        int   c;
        bit   flag;
        logic [1:0] exp_seq[7];

        //               rd wr urg prior wr_len  rd_len  valid op     wrp  rdp
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 0, 9'd8, 9'd8, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 0, 9'd8, 9'd8, 1'b1, 2'b01, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 0, 9'd8, 9'd8, 1'b1, 2'b10, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 0, 9'd8, 9'd8, 1'b1, 2'b01, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1, 9'd8, 9'd8, 1'b1, 2'b10, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 2, 9'd8, 9'd8, 1'b1, 2'b01, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 2, 9'd8, 9'd8, 1'b1, 2'b10, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1, 9'd8, 9'd8, 1'b1, 2'b10, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 0, 9'd8, 9'd8, 1'b1, 2'b01, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 0, 9'd0, 9'd8, 1'b0, 2'b00, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 0, 9'd8, 9'd0, 1'b0, 2'b00, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 0, 9'd8, 9'd0, 1'b0, 2'b00, 1'b0, 1'b1};

        // ---------------- reset state ----------------
        apply_reset();
        @(negedge clk);
        check("reset cmd_valid", 32'(cmd_valid), 32'd0);
        check("reset cmd_op", 32'(cmd_op), 32'd0);
        check("reset acks/dones", 32'({wr_ack, wr_done, rd_ack, rd_done}), 32'd0);
        check("reset pending", 32'(refresh_pending), 32'd0);
        check("reset overflow", 32'(refresh_overflow), 32'd0);

        // ---------------- table-driven arbitration vectors ----------------
        for (int i = 0; i < 12; i++) begin
            logic [AW-1:0] exp_addr;
            logic [LW-1:0] exp_len;
            apply_reset();
            if (vecs[i].prior == 1) do_txn(1'b0);
            if (vecs[i].prior == 2) do_txn(1'b1);
            wr_req    = vecs[i].wr_req;
            rd_req    = vecs[i].rd_req;
            rd_urgent = vecs[i].rd_urgent;
            wr_addr   = 22'h100000 + 22'(i);
            rd_addr   = 22'h200000 + 22'(i);
            wr_len    = vecs[i].wr_len;
            rd_len    = vecs[i].rd_len;
            exp_addr  = (vecs[i].exp_op == 2'b01) ? wr_addr : rd_addr;
            exp_len   = (vecs[i].exp_op == 2'b01) ? wr_len  : rd_len;
            @(negedge clk);
            check($sformatf("vec%0d cmd_valid", i), 32'(cmd_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d cmd_op", i), 32'(cmd_op), 32'(vecs[i].exp_op));
            check($sformatf("vec%0d wr_ack", i), 32'(wr_ack), 32'(vecs[i].exp_wr_pulse));
            check($sformatf("vec%0d wr_done", i), 32'(wr_done), 32'(vecs[i].exp_wr_pulse));
            check($sformatf("vec%0d rd_ack", i), 32'(rd_ack), 32'(vecs[i].exp_rd_pulse));
            check($sformatf("vec%0d rd_done", i), 32'(rd_done), 32'(vecs[i].exp_rd_pulse));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d cmd_addr", i), 32'(cmd_addr), 32'(exp_addr));
                check($sformatf("vec%0d cmd_len", i), 32'(cmd_len), 32'(exp_len));
            end
            wr_req = 1'b0;
            rd_req = 1'b0;
            @(negedge clk);
            if (!vecs[i].exp_valid)
                check($sformatf("vec%0d no command", i), 32'(cmd_valid), 32'd0);
        end

        // ---------------- lone write, 256 words ----------------
        apply_reset();
        wr_req  = 1'b1;
        wr_addr = 22'h012345;
        wr_len  = 9'd256;
        @(negedge clk);
        check("lone cmd_valid N+1", 32'(cmd_valid), 32'd1);
        check("lone cmd_op", 32'(cmd_op), 32'h1);
        check("lone cmd_addr", 32'(cmd_addr), 32'h012345);
        check("lone cmd_len", 32'(cmd_len), 32'd256);
        check("lone wr_ack not yet", 32'(wr_ack), 32'd0);
        @(negedge clk);
        check("lone wr_ack N+2", 32'(wr_ack), 32'd1);
        check("lone cmd_valid dropped", 32'(cmd_valid), 32'd0);
        wr_req = 1'b0;
        flag   = 1'b0;
        repeat (297) begin
            @(negedge clk);
            if (wr_done || wr_ack) flag = 1'b1;
        end
        check("lone no early done/ack", 32'(flag), 32'd0);
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;
        check("lone wr_done", 32'(wr_done), 32'd1);
        @(negedge clk);
        check("lone wr_done one cycle", 32'(wr_done), 32'd0);

        // ---------------- contention (last grant was the write above) -------
        exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10};
        rd_req  = 1'b1; rd_addr = 22'h000200; rd_len = 9'd8;
        wr_req  = 1'b1; wr_addr = 22'h000100; wr_len = 9'd8;
        for (int g = 0; g < 7; g++) begin
            wait_sig(4, 10, c);
            check($sformatf("contend grant%0d issued", g), 32'(c >= 0), 32'd1);
            check($sformatf("contend grant%0d op", g), 32'(cmd_op), 32'(exp_seq[g]));
            repeat (9) @(negedge clk);
            if (g == 3) rd_urgent = 1'b1;
            cmd_done = 1'b1;
            @(negedge clk);
            cmd_done = 1'b0;
        end
        rd_req = 1'b0; wr_req = 1'b0; rd_urgent = 1'b0;

        // ---------------- stalled handshake ----------------
        apply_reset();
        cmd_ready = 1'b0;
        wr_req    = 1'b1;
        wr_addr   = 22'h3FFFFF;
        wr_len    = 9'd32;
        @(negedge clk);
        check("stall cmd_valid", 32'(cmd_valid), 32'd1);
        flag = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(cmd_valid && cmd_op == 2'b01 && cmd_addr == 22'h3FFFFF &&
                  cmd_len == 9'd32 && !wr_ack && !wr_done)) flag = 1'b0;
            cmd_done = (i == 5);  // stray completion while in ISSUE
        end
        cmd_done = 1'b0;
        check("stall command stable, no ack", 32'(flag), 32'd1);
        cmd_ready = 1'b1;
        @(negedge clk);
        check("stall wr_ack after ready", 32'(wr_ack), 32'd1);
        check("stall cmd_valid dropped", 32'(cmd_valid), 32'd0);
        wr_req   = 1'b0;
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;
        check("stall wr_done", 32'(wr_done), 32'd1);

        // ---------------- periodic refresh ----------------
        apply_reset();
        wait_sig(7, 800, c);
        check("refresh first tick cycle", 32'(c), 32'd780);
        check("refresh pending 1", 32'(refresh_pending), 32'd1);
        @(negedge clk);
        check("refresh cmd_valid", 32'(cmd_valid), 32'd1);
        check("refresh cmd_op", 32'(cmd_op), 32'h3);
        check("refresh cmd_len", 32'(cmd_len), 32'd0);
        repeat (3) @(negedge clk);
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;
        check("refresh pending back to 0", 32'(refresh_pending), 32'd0);
        check("refresh no wr/rd done", 32'({wr_done, rd_done}), 32'd0);

        // ---------------- forced refresh and overflow ----------------
        apply_reset();
        rd_req = 1'b1; rd_urgent = 1'b1; rd_addr = 22'h000777; rd_len = 9'd16;
        wait_sig(2, 10, c);
        check("forced read acked", 32'(c >= 0), 32'd1);
        wait_sig(5, 4000, c);
        check("forced pending reached 4", 32'(c >= 0), 32'd1);
        check("forced no overflow yet", 32'(refresh_overflow), 32'd0);
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;
        check("forced rd_done", 32'(rd_done), 32'd1);
        @(negedge clk);
        check("forced refresh beats urgent read", 32'(cmd_op), 32'h3);
        check("forced refresh cmd_valid", 32'(cmd_valid), 32'd1);
        wait_sig(6, 900, c);
        check("forced overflow set", 32'(c >= 0), 32'd1);
        check("forced pending held at 4", 32'(refresh_pending), 32'd4);
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;
        check("forced pending after refresh", 32'(refresh_pending), 32'd3);
        @(negedge clk);
        check("forced urgent read next", 32'(cmd_op), 32'h2);
        check("forced overflow sticky", 32'(refresh_overflow), 32'd1);
        rd_req = 1'b0; rd_urgent = 1'b0;

        // ---------------- reset while waiting for completion ----------------
        apply_reset();
        wr_req = 1'b1; wr_addr = 22'h155555; wr_len = 9'd64;
        wait_sig(0, 10, c);
        check("midreset wr_ack seen", 32'(c >= 0), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("midreset async outputs", 32'({wr_ack, wr_done, rd_ack, rd_done, cmd_valid}), 32'd0);
        check("midreset cmd_addr", 32'(cmd_addr), 32'd0);
        check("midreset cmd_len", 32'(cmd_len), 32'd0);
        check("midreset pending", 32'(refresh_pending), 32'd0);
        wr_req = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
        cmd_done = 1'b1;
        flag     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmd_done = 1'b0;
            if (wr_done || cmd_valid) flag = 1'b1;
        end
        check("midreset no done pulse", 32'(flag), 32'd0);
        rd_req = 1'b1; rd_addr = 22'h0000AB; rd_len = 9'd8;
        @(negedge clk);
        check("postreset read issued", 32'({cmd_valid, cmd_op}), 32'b110);
        @(negedge clk);
        check("postreset rd_ack", 32'(rd_ack), 32'd1);
        rd_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
